// File: rtl/modular_sub_256_seq.sv
// rtl/modular_sub_256_seq.sv - limb-serial modular subtractor, z = (x - y) mod M
// Subtracts one limb per cycle, then adds M back limb-serially only when the difference went negative.
module modular_sub_256_seq #(
  parameter int W = 256,
  parameter int LIMB = 64,
  parameter logic [W-1:0] M = 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x_sub,
  input  logic [W-1:0] y_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z_sub
);

  localparam int NLIMB = W / LIMB;
  localparam int CW = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   x_r, y_r, r_r;
  logic [CW-1:0]  cnt;
  logic           cy;
  logic           last;
  logic [LIMB:0]  sub_limb, add_limb;
  logic [LIMB-1:0] m_limb;
  logic [W-1:0]   r_shift;

  assign last      = (cnt == CW'(NLIMB - 1));
  assign m_limb    = M[cnt*LIMB +: LIMB];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operands shift down so limb 0 is always the active one; results enter from the top,
  // so after NLIMB steps r_r holds the full word in natural order.
  always_comb begin
    sub_limb = {1'b0, x_r[LIMB-1:0]} - {1'b0, y_r[LIMB-1:0]} - {{LIMB{1'b0}}, cy};
    add_limb = {1'b0, r_r[LIMB-1:0]} + {1'b0, m_limb} + {{LIMB{1'b0}}, cy};
    if (state == FIX)
      r_shift = {add_limb[LIMB-1:0], r_r[W-1:LIMB]};
    else
      r_shift = {sub_limb[LIMB-1:0], r_r[W-1:LIMB]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = SUB;
      SUB:  if (last) state_nx = sub_limb[LIMB] ? FIX : DONE;
      FIX:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r   <= '0;
      y_r   <= '0;
      r_r   <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      z_sub <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r <= x_sub;
            y_r <= y_sub;
            cnt <= '0;
            cy  <= 1'b0;
          end
        end
        SUB: begin
          x_r <= x_r >> LIMB;
          y_r <= y_r >> LIMB;
          r_r <= r_shift;
          cnt <= last ? '0 : cnt + CW'(1);
          cy  <= sub_limb[LIMB];
          if (last) begin
            // A final borrow means the result wrapped; the fix pass starts with a clean carry.
            if (sub_limb[LIMB])
              cy <= 1'b0;
            else
              z_sub <= r_shift;
          end
        end
        FIX: begin
          r_r <= r_shift;
          cnt <= last ? '0 : cnt + CW'(1);
          cy  <= add_limb[LIMB];
          if (last)
            z_sub <= r_shift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_sub_256_seq.sv
// tb/tb_modular_sub_256_seq.sv - self-checking bench for modular_sub_256_seq
module tb_modular_sub_256_seq;

  localparam logic [255:0] MOD = 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
  localparam logic [255:0] MM2 = 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfefffffffeffffffff;
  localparam logic [255:0] MM5 = 256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfefffffffefffffffc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [255:0] x_sub = '0;
  logic [255:0] y_sub = '0;
  logic in_ready, out_valid;
  logic [255:0] z_sub;

  modular_sub_256_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_sub(x_sub), .y_sub(y_sub), .out_valid(out_valid), .out_ready(out_ready), .z_sub(z_sub)
  );

  typedef struct {
    logic [255:0] z;
    int acc;
    int lat;
  } op_t;

  op_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pops = 0;
  int last_lat = 0;
  int n_borrow = 0;
  int n_plain = 0;
  int prev_acc = -1;
  int prev_lat = 0;
  bit b2b = 1'b0;
  bit exp_ov;
  bit ov_prev = 1'b0;
  logic [255:0] held_z = '0;
  logic [255:0] last_z = '0;
  logic [255:0] rx, ry;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [255:0] ref_sub(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? a - b : MOD - (b - a);
  endfunction

  function automatic logic [255:0] rnd_red();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v % MOD;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model-driven compare: every cycle, the expected handshake state and z_sub follow from the queue of accepted ops.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      held_z = '0;
      prev_acc = -1;
      ov_prev = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_z_sub", z_sub, 0);
    end else begin
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= q[0].lat);
      check("in_ready", in_ready, q.size() == 0);
      check("out_valid", out_valid, exp_ov);
      check("z_sub", z_sub, exp_ov ? q[0].z : held_z);
      if (out_valid && !ov_prev && q.size() > 0) last_lat = cyc - q[0].acc;
      ov_prev = out_valid;
      if (out_valid && out_ready && q.size() > 0) begin
        held_z = q[0].z;
        last_z = z_sub;
        pops++;
        void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        op_t e;
        e.z = ref_sub(x_sub, y_sub);
        e.acc = cyc + 1;
        e.lat = (x_sub < y_sub) ? 8 : 4;
        if (x_sub < y_sub) n_borrow++; else n_plain++;
        if (b2b && prev_acc >= 0) check("b2b_gap", e.acc - prev_acc, prev_lat + 2);
        prev_acc = e.acc;
        prev_lat = e.lat;
        q.push_back(e);
      end
    end
  end

  task automatic send(input logic [255:0] a, input logic [255:0] b, input bit hold);
    int n;
    in_valid = 1'b1;
    x_sub = a;
    y_sub = b;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int p;
    int n;
    p = pops;
    n = 0;
    while (pops == p && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (pops == p) begin
      total++;
      bad++;
      $display("FAIL out_timeout: pops got %0d expected %0d", pops, p + 1);
    end
    #1;
  endtask

  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [255:0] ez, input int elat);
    send(a, b, 1'b0);
    wait_out();
    check("op_z", last_z, ez);
    check("op_latency", last_lat, elat);
  endtask

  initial begin
    #1_000_000;
    total++;
    bad++;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("model_5_3", ref_sub(256'd5, 256'd3), 256'd2);
    check("model_3_5", ref_sub(256'd3, 256'd5), MM2);

    run_op(256'd5, 256'd3, 256'd2, 4);
    run_op(256'd3, 256'd5, MM2, 8);
    run_op(256'd0, MOD - 256'd1, 256'd1, 8);
    run_op(MOD - 256'd1, 256'd0, MOD - 256'd1, 4);
    run_op(256'h1234, 256'h1234, 256'd0, 4);

    // Backpressure: result must sit stable while out_ready is low.
    out_ready = 1'b0;
    send(256'd9, 256'd4, 1'b0);
    for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_z", z_sub, 256'd5);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_out();
    run_op(256'd4, 256'd9, MM5, 8);

    // Abort mid-operation with reset.
    send(256'd3, 256'd5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_in_ready", in_ready, 1);
    end
    run_op(256'd7, 256'd9, MM2, 8);

    for (int i = 0; i < 2000; i++) begin
      rx = rnd_red();
      ry = rnd_red();
      if (i % 8 == 0) ry = rx;
      if (i % 8 == 1) rx = 256'(i);
      if (i % 8 == 2) ry = MOD - 256'd1;
      send(rx, ry, 1'b0);
      wait_out();
    end

    // Back-to-back: in_valid and out_ready held high, accepts must be lat+2 apart.
    b2b = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rx = rnd_red();
      ry = rnd_red();
      send(rx, ry, 1'b1);
    end
    in_valid = 1'b0;
    for (int n = 0; n < 40 && q.size() > 0; n++) @(posedge clk);
    check("b2b_drained", q.size(), 0);
    b2b = 1'b0;

    check("cov_borrow_path", n_borrow > 100, 1);
    check("cov_plain_path", n_plain > 100, 1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
